// File: rtl/time_set_ctrl_pkg.sv
// Shared definitions for the time-set controller: FSM states, field codes and BCD limits.
package time_set_ctrl_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_EDIT_HR,
        ST_EDIT_MIN,
        ST_EDIT_SEC,
        ST_EDIT_AMPM,
        ST_COMMIT,
        ST_HOLD
    } state_e;

    typedef enum logic [1:0] {
        FLD_HR   = 2'b00,
        FLD_MIN  = 2'b01,
        FLD_SEC  = 2'b10,
        FLD_AMPM = 2'b11
    } field_e;

    localparam logic [7:0] BCD_00 = 8'h00;
    localparam logic [7:0] BCD_01 = 8'h01;
    localparam logic [7:0] BCD_12 = 8'h12;
    localparam logic [7:0] BCD_59 = 8'h59;

    function automatic logic is_edit(input state_e s);
        return (s == ST_EDIT_HR) || (s == ST_EDIT_MIN) || (s == ST_EDIT_SEC) || (s == ST_EDIT_AMPM);
    endfunction

endpackage

// File: rtl/time_set_ctrl_if.sv
// Button/time bundle between the front panel, the clock core and the time-set controller.
interface time_set_ctrl_if;
    logic        btn_mode;
    logic        btn_inc;
    logic        btn_dec;
    logic [23:0] cur_time;
    logic        cur_am;
    logic [7:0]  hr_out;
    logic [7:0]  min_out;
    logic [7:0]  sec_out;
    logic        day_night;
    logic        set_out;
    logic        editing;
    logic [1:0]  field_sel;

    modport master (
        output btn_mode, btn_inc, btn_dec, cur_time, cur_am,
        input  hr_out, min_out, sec_out, day_night, set_out, editing, field_sel
    );

    modport slave (
        input  btn_mode, btn_inc, btn_dec, cur_time, cur_am,
        output hr_out, min_out, sec_out, day_night, set_out, editing, field_sel
    );
endinterface

// File: rtl/time_set_ctrl_bcd_field_step.sv
// One BCD up/down step inside [min,max] with wrap; out-of-range inputs snap to the opposite limit.
module time_set_ctrl_bcd_field_step (
    input  logic [7:0] val_i,
    input  logic [7:0] min_i,
    input  logic [7:0] max_i,
    input  logic       up_i,
    output logic [7:0] nxt_o
);
    always_comb begin
        nxt_o = val_i;
        if (up_i) begin
            if (val_i >= max_i)           nxt_o = min_i;
            else if (val_i[3:0] >= 4'd9)  nxt_o = {val_i[7:4] + 4'd1, 4'd0};
            else                          nxt_o = {val_i[7:4], val_i[3:0] + 4'd1};
        end else begin
            if (val_i <= min_i)           nxt_o = max_i;
            else if (val_i[3:0] == 4'd0)  nxt_o = {val_i[7:4] - 4'd1, 4'd9};
            else if (val_i[3:0] > 4'd9)   nxt_o = {val_i[7:4], 4'd9};
            else                          nxt_o = {val_i[7:4], val_i[3:0] - 4'd1};
        end
    end
endmodule

// File: rtl/time_set_ctrl.sv
// Button-driven time-set controller: capture running time, edit HR/MIN/SEC/AMPM, then strobe set_out.
module time_set_ctrl
    import time_set_ctrl_pkg::*;
#(
    parameter int TIMEOUT_CYC = 1_000_000,
    parameter int REPEAT_DLY  = 50_000,
    parameter int REPEAT_PER  = 10_000,
    parameter int SET_HOLD    = 4
) (
    input  logic           clk,
    input  logic           reset_n,
    time_set_ctrl_if.slave bus
);
    localparam int TO_W   = (TIMEOUT_CYC > 1) ? $clog2(TIMEOUT_CYC) : 1;
    localparam int RPT_MX = (REPEAT_DLY > REPEAT_PER) ? REPEAT_DLY : REPEAT_PER;
    localparam int RPT_W  = $clog2(RPT_MX + 1);
    localparam int HLD_W  = (SET_HOLD > 1) ? $clog2(SET_HOLD) : 1;

    localparam logic [TO_W-1:0]  TO_LAST   = TO_W'(TIMEOUT_CYC - 1);
    localparam logic [RPT_W-1:0] RPT_DLY_C = RPT_W'(REPEAT_DLY);
    localparam logic [RPT_W-1:0] RPT_PER_C = RPT_W'(REPEAT_PER);
    localparam logic [HLD_W-1:0] HLD_LAST  = HLD_W'(SET_HOLD - 1);

    state_e           state_q, state_d;
    field_e           fsel_q, fsel_d;
    logic [TO_W-1:0]  to_q, to_d;
    logic [RPT_W-1:0] rpt_q, rpt_d, rpt_inc;
    logic [HLD_W-1:0] hld_q, hld_d;
    logic             rep_q, rep_d;
    logic             mode_q, inc_q, dec_q;
    logic [7:0]       hr_q, hr_d, min_q, min_d, sec_q, sec_d;
    logic             am_q, am_d, set_q, set_d, edit_q, edit_d;

    logic       mode_p, inc_p, dec_p, any_p, in_edit, tmo;
    logic       hold_ok, rpt_fire, up_ev, dn_ev, step;
    logic [7:0] fld_val, fld_min, fld_max, fld_nxt;

    always_comb begin
        mode_p  = bus.btn_mode & ~mode_q;
        inc_p   = bus.btn_inc & ~inc_q;
        dec_p   = bus.btn_dec & ~dec_q;
        any_p   = mode_p | inc_p | dec_p;
        in_edit = is_edit(state_q);
        tmo     = in_edit & ~any_p & (to_q == TO_LAST);
        // Auto-repeat only runs while exactly one of inc/dec is held past its press.
        hold_ok  = in_edit & ~any_p & (bus.btn_inc ^ bus.btn_dec);
        rpt_inc  = rpt_q + RPT_W'(1);
        rpt_fire = hold_ok & (rpt_inc == (rep_q ? RPT_PER_C : RPT_DLY_C));
        rpt_d    = (hold_ok && !rpt_fire) ? rpt_inc : '0;
        rep_d    = hold_ok & (rep_q | rpt_fire);
        up_ev    = inc_p | (rpt_fire & bus.btn_inc);
        dn_ev    = dec_p | (rpt_fire & bus.btn_dec);
        step     = in_edit & ~mode_p & (up_ev ^ dn_ev);
    end

    always_comb begin
        fld_val = hr_q;
        fld_min = BCD_01;
        fld_max = BCD_12;
        case (fsel_q)
            FLD_MIN: begin fld_val = min_q; fld_min = BCD_00; fld_max = BCD_59; end
            FLD_SEC: begin fld_val = sec_q; fld_min = BCD_00; fld_max = BCD_59; end
            default: ;
        endcase
    end

    time_set_ctrl_bcd_field_step u_step (
        .val_i (fld_val),
        .min_i (fld_min),
        .max_i (fld_max),
        .up_i  (up_ev),
        .nxt_o (fld_nxt)
    );

    always_comb begin
        state_d = state_q;
        hr_d    = hr_q;
        min_d   = min_q;
        sec_d   = sec_q;
        am_d    = am_q;
        case (state_q)
            ST_IDLE: if (mode_p) begin
                state_d = ST_EDIT_HR;
                hr_d    = bus.cur_time[23:16];
                min_d   = bus.cur_time[15:8];
                sec_d   = bus.cur_time[7:0];
                am_d    = bus.cur_am;
            end
            ST_EDIT_HR:   if (mode_p) state_d = ST_EDIT_MIN;  else if (tmo) state_d = ST_IDLE;
            ST_EDIT_MIN:  if (mode_p) state_d = ST_EDIT_SEC;  else if (tmo) state_d = ST_IDLE;
            ST_EDIT_SEC:  if (mode_p) state_d = ST_EDIT_AMPM; else if (tmo) state_d = ST_IDLE;
            ST_EDIT_AMPM: if (mode_p) state_d = ST_COMMIT;    else if (tmo) state_d = ST_IDLE;
            ST_COMMIT:    state_d = ST_HOLD;
            ST_HOLD:      if (hld_q == HLD_LAST) state_d = ST_IDLE;
            default:      state_d = ST_IDLE;
        endcase

        if (step) begin
            case (fsel_q)
                FLD_HR:   hr_d  = fld_nxt;
                FLD_MIN:  min_d = fld_nxt;
                FLD_SEC:  sec_d = fld_nxt;
                FLD_AMPM: am_d  = ~am_q;
                default:  ;
            endcase
        end

        to_d   = (state_d != state_q || any_p || !in_edit) ? '0 : to_q + TO_W'(1);
        hld_d  = (state_q == ST_HOLD && state_d == ST_HOLD) ? hld_q + HLD_W'(1) : '0;
        set_d  = (state_d == ST_HOLD);
        edit_d = is_edit(state_d);
        case (state_d)
            ST_EDIT_MIN:  fsel_d = FLD_MIN;
            ST_EDIT_SEC:  fsel_d = FLD_SEC;
            ST_EDIT_AMPM: fsel_d = FLD_AMPM;
            default:      fsel_d = FLD_HR;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= ST_IDLE;
            fsel_q  <= FLD_HR;
            to_q    <= '0;
            rpt_q   <= '0;
            rep_q   <= 1'b0;
            hld_q   <= '0;
            mode_q  <= 1'b0;
            inc_q   <= 1'b0;
            dec_q   <= 1'b0;
            hr_q    <= BCD_12;
            min_q   <= BCD_00;
            sec_q   <= BCD_00;
            am_q    <= 1'b1;
            set_q   <= 1'b0;
            edit_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            fsel_q  <= fsel_d;
            to_q    <= to_d;
            rpt_q   <= rpt_d;
            rep_q   <= rep_d;
            hld_q   <= hld_d;
            mode_q  <= bus.btn_mode;
            inc_q   <= bus.btn_inc;
            dec_q   <= bus.btn_dec;
            hr_q    <= hr_d;
            min_q   <= min_d;
            sec_q   <= sec_d;
            am_q    <= am_d;
            set_q   <= set_d;
            edit_q  <= edit_d;
        end
    end

    assign bus.hr_out    = hr_q;
    assign bus.min_out   = min_q;
    assign bus.sec_out   = sec_q;
    assign bus.day_night = am_q;
    assign bus.set_out   = set_q;
    assign bus.editing   = edit_q;
    assign bus.field_sel = fsel_q;

    ap_set_only_in_hold: assert property (@(posedge clk) disable iff (!reset_n)
        set_q |-> (state_q == ST_HOLD));

endmodule

// File: tb/tb_time_set_ctrl.sv
// Bench for time_set_ctrl: directed scenarios plus random button traffic against a decimal-arithmetic model.
module tb_time_set_ctrl;
    localparam int TO   = 100;
    localparam int DLY  = 8;
    localparam int PER  = 3;
    localparam int HOLD = 4;

    logic clk = 1'b0;
    logic reset_n = 1'b0;
    time_set_ctrl_if bus();

    time_set_ctrl #(
        .TIMEOUT_CYC (TO),
        .REPEAT_DLY  (DLY),
        .REPEAT_PER  (PER),
        .SET_HOLD    (HOLD)
    ) dut (
        .clk     (clk),
        .reset_n (reset_n),
        .bus     (bus)
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_err = 0;

    // Model: edit flag, field index 0..3, remaining commit/hold cycles, decimal time.
    bit m_edit, m_am, m_pm, m_pi, m_pd;
    int m_fld, m_post, m_hr, m_mn, m_sc, m_held, m_idle;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    function automatic logic [7:0] to_bcd(input int v);
        return {4'(v / 10), 4'(v % 10)};
    endfunction

    function automatic int from_bcd(input logic [7:0] b);
        return int'(b[7:4]) * 10 + int'(b[3:0]);
    endfunction

    task automatic model_reset();
        m_edit = 0; m_fld = 0; m_post = 0;
        m_hr = 12; m_mn = 0; m_sc = 0; m_am = 1;
        m_pm = 0; m_pi = 0; m_pd = 0; m_held = 0; m_idle = 0;
    endtask

    task automatic step_field(input bit up);
        case (m_fld)
            0: m_hr = up ? (m_hr % 12) + 1 : ((m_hr + 10) % 12) + 1;
            1: m_mn = up ? (m_mn + 1) % 60 : (m_mn + 59) % 60;
            2: m_sc = up ? (m_sc + 1) % 60 : (m_sc + 59) % 60;
            default: m_am = !m_am;
        endcase
    endtask

    task automatic model_edge(input bit m, input bit i, input bit d);
        bit mp, ip, dp, one, rpt, up, dn;
        mp = m && !m_pm; ip = i && !m_pi; dp = d && !m_pd;
        m_pm = m; m_pi = i; m_pd = d;
        if (m_post > 0) begin
            m_post--;
            m_held = 0;
        end else if (!m_edit) begin
            m_held = 0;
            m_idle = 0;
            if (mp) begin
                m_edit = 1; m_fld = 0;
                m_hr = from_bcd(bus.cur_time[23:16]);
                m_mn = from_bcd(bus.cur_time[15:8]);
                m_sc = from_bcd(bus.cur_time[7:0]);
                m_am = bus.cur_am;
            end
        end else begin
            one    = (i != d) && !ip && !dp && !mp;
            m_held = one ? m_held + 1 : 0;
            rpt    = one && (m_held >= DLY) && ((m_held - DLY) % PER == 0);
            up     = ip || (rpt && i);
            dn     = dp || (rpt && d);
            if (mp) begin
                m_idle = 0;
                if (m_fld == 3) begin m_edit = 0; m_post = HOLD + 1; end
                else m_fld++;
            end else begin
                if (up != dn) step_field(up);
                if (ip || dp) m_idle = 0;
                else if (m_idle == TO - 1) begin m_edit = 0; m_idle = 0; end
                else m_idle++;
            end
        end
    endtask

    task automatic check_outs();
        chk("hr_out",    32'(bus.hr_out),    32'(to_bcd(m_hr)));
        chk("min_out",   32'(bus.min_out),   32'(to_bcd(m_mn)));
        chk("sec_out",   32'(bus.sec_out),   32'(to_bcd(m_sc)));
        chk("day_night", 32'(bus.day_night), 32'(m_am));
        chk("set_out",   32'(bus.set_out),   32'(m_post >= 1 && m_post <= HOLD));
        chk("editing",   32'(bus.editing),   32'(m_edit));
        if (m_edit) chk("field_sel", 32'(bus.field_sel), 32'(m_fld));
    endtask

    task automatic cyc(input bit m, input bit i, input bit d);
        bus.btn_mode = m; bus.btn_inc = i; bus.btn_dec = d;
        @(posedge clk);
        model_edge(m, i, d);
        @(negedge clk);
        check_outs();
    endtask

    task automatic press(input bit m, input bit i, input bit d);
        cyc(m, i, d);
        cyc(0, 0, 0);
    endtask

    task automatic do_reset(input string tag);
        #2 reset_n = 1'b0;
        #1;
        chk({tag, "_set"},  32'(bus.set_out), 32'd0);
        chk({tag, "_edit"}, 32'(bus.editing), 32'd0);
        chk({tag, "_hr"},   32'(bus.hr_out),  32'h12);
        model_reset();
        @(negedge clk);
        reset_n = 1'b1;
    endtask

    initial begin
        bit rm, ri, rd;
        bus.btn_mode = 0; bus.btn_inc = 0; bus.btn_dec = 0;
        bus.cur_time = 24'h0; bus.cur_am = 1'b1;
        model_reset();
        repeat (2) @(negedge clk);
        chk("rst_hr",   32'(bus.hr_out),    32'h12);
        chk("rst_min",  32'(bus.min_out),   32'h00);
        chk("rst_sec",  32'(bus.sec_out),   32'h00);
        chk("rst_dn",   32'(bus.day_night), 32'd1);
        chk("rst_set",  32'(bus.set_out),   32'd0);
        chk("rst_edit", 32'(bus.editing),   32'd0);
        chk("rst_fsel", 32'(bus.field_sel), 32'd0);
        reset_n = 1'b1;

        bus.cur_time = 24'h10_27_45; bus.cur_am = 1'b0;
        cyc(1, 0, 0);
        chk("cap_edit", 32'(bus.editing), 32'd1);
        chk("cap_hr",   32'(bus.hr_out),  32'h10);
        chk("cap_min",  32'(bus.min_out), 32'h27);
        chk("cap_sec",  32'(bus.sec_out), 32'h45);
        chk("cap_dn",   32'(bus.day_night), 32'd0);
        cyc(0, 0, 0);

        press(0, 1, 0); press(0, 1, 0);
        chk("hr_to12", 32'(bus.hr_out), 32'h12);
        press(0, 1, 0);
        chk("hr_wrap_inc", 32'(bus.hr_out), 32'h01);
        press(0, 0, 1);
        chk("hr_wrap_dec", 32'(bus.hr_out), 32'h12);

        press(1, 0, 0);
        repeat (28) press(0, 0, 1);
        chk("min_dec59", 32'(bus.min_out), 32'h59);
        press(0, 1, 0);
        chk("min_wrap_inc", 32'(bus.min_out), 32'h00);
        repeat (9) press(0, 1, 0);
        chk("min_09", 32'(bus.min_out), 32'h09);
        press(0, 1, 0);
        chk("min_carry", 32'(bus.min_out), 32'h10);
        press(0, 1, 1);
        chk("incdec_nostep", 32'(bus.min_out), 32'h10);

        press(1, 0, 0);
        repeat (15) press(0, 1, 0);
        chk("sec_00", 32'(bus.sec_out), 32'h00);
        press(0, 0, 1);
        chk("sec_wrap_dec", 32'(bus.sec_out), 32'h59);

        repeat (98) cyc(0, 0, 0);
        chk("to_still_edit", 32'(bus.editing), 32'd1);
        cyc(0, 0, 0);
        chk("to_abort", 32'(bus.editing), 32'd0);
        chk("to_keep_sec", 32'(bus.sec_out), 32'h59);

        bus.cur_time = 24'h06_31_01; bus.cur_am = 1'b1;
        press(1, 0, 0); press(0, 1, 0);
        press(1, 0, 0); press(0, 0, 1);
        press(1, 0, 0); press(0, 0, 1);
        press(1, 0, 0); press(0, 1, 0);
        cyc(1, 0, 0);
        chk("commit_set0", 32'(bus.set_out), 32'd0);
        for (int k = 0; k < HOLD; k++) begin
            cyc(0, 0, 0);
            chk("hold_set", 32'(bus.set_out), 32'd1);
            chk("hold_val", {bus.hr_out, bus.min_out, bus.sec_out, 7'd0, bus.day_night}, 32'h07_30_00_00);
        end
        cyc(0, 0, 0);
        chk("hold_end", 32'(bus.set_out), 32'd0);

        bus.cur_time = 24'h01_02_00; bus.cur_am = 1'b1;
        press(1, 0, 0); press(1, 0, 0); press(1, 0, 0);
        cyc(0, 1, 0);
        repeat (DLY + PER * 5) cyc(0, 1, 0);
        chk("rpt_sec07", 32'(bus.sec_out), 32'h07);
        repeat (10) cyc(0, 0, 0);
        chk("rpt_release", 32'(bus.sec_out), 32'h07);

        press(1, 0, 0);
        cyc(1, 0, 0); cyc(0, 0, 0); cyc(0, 0, 0);
        chk("hold2_set", 32'(bus.set_out), 32'd1);
        do_reset("hold_rst");
        repeat (10) cyc(0, 0, 0);

        rm = 0; ri = 0; rd = 0;
        for (int n = 0; n < 4000; n++) begin
            if ($urandom_range(0, 19) == 0) rm = !rm;
            if ($urandom_range(0, 9) == 0)  ri = !ri;
            if ($urandom_range(0, 9) == 0)  rd = !rd;
            bus.cur_time = {to_bcd($urandom_range(1, 12)), to_bcd($urandom_range(0, 59)),
                            to_bcd($urandom_range(0, 59))};
            bus.cur_am = 1'($urandom_range(0, 1));
            if ($urandom_range(0, 799) == 0) do_reset("rnd_rst");
            else cyc(rm, ri, rd);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
